mu0_io_responder: RTL and testbench
===================================

# mu0_io_responder

Memory-mapped peripheral that responds to MU0 bus cycles (Addr/Wr/write-data from the processor, read-data back to it) alongside MU0_Memory. It decodes an 8-word window at BASE and provides a countdown timer and a 4-deep transmit FIFO drained over a valid/ready stream. The top level muxes Rdata onto the processor's Din whenever Sel is high.

## Interface
Parameters:
- BASE, 12'hFF0, first word address of the window; bits [2:0] must be 0.
- PRESCALE, 1, clock cycles per timer tick; minimum 1.
- DEPTH, 4, TX FIFO entries; power of two, minimum 2.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Addr  in  12  processor address.
- Wdata  in  16  processor write data (MU0 Dout).
- Wr  in  1  processor write strobe.
- Rdata  out  16  registered read data (to MU0 Din via top-level mux).
- Sel  out  1  registered; high when the previous cycle's Addr was in the window.
- Tx_data  out  16  FIFO head word.
- Tx_valid  out  1  FIFO non-empty.
- Tx_ready  in  1  consumer accepts Tx_data this cycle.

## Operation
Register map (offset from BASE):
- +0 LOAD (RW): write sets reload value and current count; resets the prescaler.
- +1 COUNT (R): current count. Writes are ignored.
- +2 CTRL (RW): bit0 EN, bit1 AUTO; bits [15:2] read 0.
- +3 STATUS (R, W1C): bit0 EXP sticky, bit1 FULL, bit2 EMPTY, bit3 OVF sticky, bits [6:4] LEVEL (0..DEPTH), remaining bits 0. Writing 1 to bit0 or bit3 clears that bit.
- +4 TX (W): push Wdata into the FIFO. Reads return 0.
- +5..+7: reads return 0; writes are ignored.

Timer:
- The prescaler counts while EN=1. Each PRESCALE cycles it issues one tick.
- On a tick with COUNT>1: COUNT decrements.
- On a tick with COUNT==1: COUNT becomes 0 and EXP sets.
- On a tick with COUNT==0:
  - AUTO=1: COUNT reloads from LOAD.
  - AUTO=0: EN clears.
- Writing LOAD=0 while EN=1 does not set EXP.

FIFO:
- A push on a TX write is accepted when not full, or when full and a pop occurs in the same cycle.
- A push that is not accepted is dropped and sets OVF.
- Pop happens when Tx_valid && Tx_ready.
- Simultaneous push and pop keeps LEVEL unchanged; on an empty FIFO, the pushed word appears next cycle.
- Pointers wrap modulo DEPTH.

Simultaneous events:
- Hardware set of EXP or OVF in the same cycle as a W1C clear: the set wins.
- A CTRL write in the same cycle as an auto-clear of EN: the CTRL write wins.
- A LOAD write in the same cycle as a tick: the LOAD write wins.

Reset values:
- Rdata=0, Sel=0, Tx_valid=0, Tx_data=0.
- LOAD=0, COUNT=0, CTRL=0, EXP=0, OVF=0.
- FIFO empty, prescaler=0.
- Reset mid-operation discards FIFO contents and timer state immediately; no Tx handshake completes while Reset is high.

## Timing
- Writes take effect at the rising edge where Wr=1 and Addr is in the window. Writes outside the window are ignored.
- Read latency is one cycle: Rdata and Sel reflect the Addr sampled at the previous edge, with register values as they were before that edge's updates.
- Sel is independent of Wr.
- Tx_data and Tx_valid are registered/pointer-driven and change only on Clk edges. Tx_data is stable while Tx_valid=1 and Tx_ready=0.
- A TX write at edge N gives Tx_valid=1 after edge N when the FIFO was empty.
- EXP is visible in STATUS on the read issued in the cycle after the tick edge.

## Test plan
- Reset, then read +0..+7 → all 0, except STATUS=16'h0004 (EMPTY); Sel=1 one cycle after each read address, Sel=0 for Addr=12'h010.
- PRESCALE=1: LOAD=3, CTRL=1 → COUNT reads 2,1,0 on consecutive cycles; EXP=1; EN self-clears; W1C 16'h0001 to STATUS → EXP=0.
- LOAD=2, CTRL=3 (auto) → COUNT sequence 1,0,2,1,0; EXP sets; EN stays 1.
- Tx_ready=0, push 16'hA001..16'hA005 → LEVEL=4, FULL=1, OVF=1; then Tx_ready=1 → Tx_data streams A001..A004 one per cycle, then EMPTY.
- Full FIFO with Tx_ready=1 and a TX write of 16'hBEEF in the same cycle → pushed, LEVEL stays 4, OVF unchanged; BEEF emerges last.
- Assert Reset mid-stream with LEVEL=3 and the timer running → Tx_valid=0 and COUNT=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/mu0_io_responder.sv
// mu0_io_responder: MU0 bus peripheral with an 8-word register window,
// a prescaled countdown timer and a transmit FIFO drained over valid/ready.
module mu0_io_responder #(
    parameter logic [11:0] BASE     = 12'hFF0,
    parameter int          PRESCALE = 1,
    parameter int          DEPTH    = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [11:0] Addr,
    input  logic [15:0] Wdata,
    input  logic        Wr,
    output logic [15:0] Rdata,
    output logic        Sel,
    output logic [15:0] Tx_data,
    output logic        Tx_valid,
    input  logic        Tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [15:0]   load, count, count_n, rd_val;
    logic          en, en_n, auto_rl, exp_f, exp_n, ovf, ovf_n;
    logic [PW-1:0] pre, pre_n;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [LW-1:0] level;
    logic [2:0]    off;
    logic          in_win, we, ld_wr, ctrl_wr, st_wr, tick, pop, push, accept, full, empty;

    assign in_win   = Addr[11:3] == BASE[11:3];
    assign off      = Addr[2:0];
    assign we       = Wr && in_win;
    assign ld_wr    = we && off == 3'd0;
    assign ctrl_wr  = we && off == 3'd2;
    assign st_wr    = we && off == 3'd3;
    assign push     = we && off == 3'd4;
    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign Tx_valid = !empty;
    assign Tx_data  = empty ? '0 : mem[rptr];
    assign pop      = Tx_valid && Tx_ready;
    // a push into a full FIFO still fits when the head leaves in the same cycle
    assign accept   = push && (!full || pop);
    assign tick     = en && pre == PMAX;

    always_comb begin
        count_n = ld_wr ? Wdata : !tick ? count : count != '0 ? count - 16'd1 : auto_rl ? load : '0;
        pre_n   = ld_wr || tick ? '0 : en ? pre + PW'(1) : pre;
        en_n    = ctrl_wr ? Wdata[0] : tick && count == '0 && !auto_rl ? 1'b0 : en;
        exp_n   = (exp_f && !(st_wr && Wdata[0])) || (tick && count == 16'd1);
        ovf_n   = (ovf && !(st_wr && Wdata[3])) || (push && !accept);
        rd_val  = off == 3'd0 ? load :
                  off == 3'd1 ? count :
                  off == 3'd2 ? {14'd0, auto_rl, en} :
                  off == 3'd3 ? {9'd0, 3'(level), ovf, empty, full, exp_f} : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            load    <= '0;
            count   <= '0;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            exp_f   <= 1'b0;
            ovf     <= 1'b0;
            pre     <= '0;
            rptr    <= '0;
            wptr    <= '0;
            level   <= '0;
            Rdata   <= '0;
            Sel     <= 1'b0;
        end else begin
            if (ld_wr) load <= Wdata;
            if (ctrl_wr) auto_rl <= Wdata[1];
            count <= count_n;
            en    <= en_n;
            pre   <= pre_n;
            exp_f <= exp_n;
            ovf   <= ovf_n;
            if (pop) rptr <= rptr + AW'(1);
            if (accept) wptr <= wptr + AW'(1);
            level <= level + LW'(accept) - LW'(pop);
            Rdata <= in_win ? rd_val : '0;
            Sel   <= in_win;
        end
    end

    // storage needs no reset: Tx_data is masked while the FIFO is empty
    always_ff @(posedge Clk)
        if (accept) mem[wptr] <= Wdata;
endmodule

// File: tb/tb_mu0_io_responder.sv
// tb_mu0_io_responder: table vectors, directed corner sequences and random
// traffic checked against a queue-based behavioural model of the peripheral.
module tb_mu0_io_responder;
    localparam logic [11:0] BASE = 12'hFF0;
    localparam int PRESCALE = 1;
    localparam int DEPTH = 4;

    logic Clk = 1'b0, Reset = 1'b1, Wr = 1'b0, Tx_ready = 1'b0;
    logic [11:0] Addr = '0;
    logic [15:0] Wdata = '0;
    logic [15:0] Rdata, Tx_data;
    logic Sel, Tx_valid;
    int checks = 0, failures = 0;
    bit rdy = 0;

    int m_load, m_count, m_pre, m_rdata;
    bit m_en, m_auto, m_exp, m_ovf, m_sel;
    int q[$];

    typedef struct {
        logic [11:0] addr;
        int rdata;
        bit sel;
    } vec_t;
    vec_t tbl[9];

    always #5 Clk = ~Clk;

    mu0_io_responder #(.BASE(BASE), .PRESCALE(PRESCALE), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .Wdata(Wdata), .Wr(Wr),
        .Rdata(Rdata), .Sel(Sel), .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_count = 0; m_pre = 0; m_rdata = 0;
        m_en = 0; m_auto = 0; m_exp = 0; m_ovf = 0; m_sel = 0;
        q.delete();
    endtask

    function automatic int reg_read(input int off);
        int n = q.size();
        case (off)
            0: return m_load;
            1: return m_count;
            2: return {m_auto, m_en};
            3: return int'(m_exp) | (int'(n == DEPTH) << 1) | (int'(n == 0) << 2) | (int'(m_ovf) << 3) | (n << 4);
            default: return 0;
        endcase
    endfunction

    task automatic step(input logic [11:0] a, input logic [15:0] d, input bit w, input bit r);
        bit inw, we, tick, exp_set, pop, push, ovf_set, n_en;
        int off, n_count, n_pre;
        @(negedge Clk);
        Addr = a; Wdata = d; Wr = w; Tx_ready = r;
        inw = a[11:3] == BASE[11:3];
        off = int'(a[2:0]);
        we = w && inw;
        @(posedge Clk);
        if (Reset) model_reset();
        else begin
            m_rdata = inw ? reg_read(off) : 0;
            m_sel = inw;
            tick = m_en && m_pre == PRESCALE - 1;
            n_pre = !m_en ? m_pre : tick ? 0 : m_pre + 1;
            n_count = m_count; n_en = m_en; exp_set = 0;
            if (tick) begin
                if (m_count > 0) begin
                    n_count = m_count - 1;
                    exp_set = m_count == 1;
                end else if (m_auto) n_count = m_load;
                else n_en = 0;
            end
            if (we && off == 0) begin m_load = d; n_count = d; n_pre = 0; end
            if (we && off == 2) begin n_en = d[0]; m_auto = d[1]; end
            m_count = n_count; m_en = n_en; m_pre = n_pre;
            pop = q.size() > 0 && r;
            push = we && off == 4;
            ovf_set = push && q.size() == DEPTH && !pop;
            if (pop) void'(q.pop_front());
            if (push && !ovf_set) q.push_back(int'(d));
            m_exp = (m_exp && !(we && off == 3 && d[0])) || exp_set;
            m_ovf = (m_ovf && !(we && off == 3 && d[3])) || ovf_set;
        end
        #1;
        check("rdata", Rdata, m_rdata);
        check("sel", Sel, m_sel);
        check("tx_valid", Tx_valid, q.size() > 0);
        if (q.size() > 0) check("tx_data", Tx_data, q[0]);
    endtask

    task automatic wreg(input int o, input int d);
        step(BASE + 12'(o), 16'(d), 1, rdy);
    endtask

    task automatic rreg(input int o);
        step(BASE + 12'(o), 16'd0, 0, rdy);
    endtask

    initial begin
        logic [11:0] a;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("rst_rdata", Rdata, 0);
        check("rst_sel", Sel, 0);
        check("rst_valid", Tx_valid, 0);
        check("rst_txdata", Tx_data, 0);

        for (int i = 0; i < 8; i++) tbl[i] = '{BASE + 12'(i), (i == 3) ? 16'h0004 : 0, 1'b1};
        tbl[8] = '{12'h010, 0, 1'b0};
        foreach (tbl[i]) begin
            step(tbl[i].addr, 16'd0, 0, 0);
            check("tbl_rdata", Rdata, tbl[i].rdata);
            check("tbl_sel", Sel, tbl[i].sel);
        end

        wreg(0, 3); wreg(2, 1);
        for (int i = 0; i < 4; i++) begin rreg(1); check("count_seq", Rdata, 3 - i); end
        rreg(2); check("en_selfclr", Rdata, 0);
        rreg(3); check("exp_set", Rdata, 16'h0005);
        wreg(3, 1); rreg(3); check("exp_w1c", Rdata, 16'h0004);

        wreg(0, 2); wreg(2, 3);
        for (int i = 0; i < 6; i++) begin rreg(1); check("auto_seq", Rdata, 2 - (i % 3)); end
        rreg(2); check("auto_en", Rdata, 3);
        wreg(2, 0);
        rreg(3); check("auto_exp", Rdata, 16'h0005);
        wreg(3, 1);

        for (int i = 1; i <= 5; i++) wreg(4, 16'hA000 + i);
        rreg(3); check("full_status", Rdata, 16'h004A);
        check("head", Tx_data, 16'hA001);
        rdy = 1;
        for (int i = 2; i <= 4; i++) begin rreg(5); check("stream", Tx_data, 16'hA000 + i); end
        rreg(5); check("drained", Tx_valid, 0);
        rreg(3); check("empty_ovf", Rdata, 16'h000C);
        wreg(3, 8);

        rdy = 0;
        for (int i = 1; i <= 4; i++) wreg(4, 16'hC000 + i);
        rdy = 1; wreg(4, 16'hBEEF); rdy = 0;
        check("beef_head", Tx_data, 16'hC002);
        rreg(3); check("beef_status", Rdata, 16'h0042);
        rdy = 1;
        for (int i = 0; i < 3; i++) rreg(5);
        check("beef_last", Tx_data, 16'hBEEF);
        rreg(5); check("beef_drained", Tx_valid, 0);

        rdy = 0;
        wreg(4, 1); wreg(4, 2); wreg(4, 3); wreg(0, 100); wreg(2, 1); rreg(1);
        @(negedge Clk); #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check("async_valid", Tx_valid, 0);
        check("async_rdata", Rdata, 0);
        check("async_sel", Sel, 0);
        rdy = 1;
        rreg(1); rreg(4);
        Reset = 1'b0;
        rreg(1); check("rst_count", Rdata, 0);
        rreg(3); check("rst_status", Rdata, 16'h0004);

        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : BASE + 12'($urandom_range(0, 7));
            step(a, (a == BASE) ? 16'($urandom_range(0, 5)) : 16'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
